// File: rtl/compare_seq.sv
// rtl/compare_seq.sv - multi-cycle MSB-first signed/unsigned magnitude comparator
// Optional feature macro: COMPARE_EARLY_EXIT_EN (finish on the first differing slice)
module compare_seq #(
   parameter int WIDTH = 8,
   parameter int SLICE = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             signed_mode_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             re_o,
   output logic             reb_o,
   output logic             eq_o
);

   localparam int NSTEP = WIDTH / SLICE;
   localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(NSTEP - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    step_q, step_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             gt_q, gt_d;
   logic             lt_q, lt_d;
   logic             re_q, re_d;
   logic             reb_q, reb_d;
   logic             eq_q, eq_d;

   logic             accept;
   logic [WIDTH-1:0] sign_flip;
   logic [SLICE-1:0] a_sl;
   logic [SLICE-1:0] b_sl;
   logic             gt_step;
   logic             lt_step;
   logic             finish;

   // A start is taken whenever no compare is running, including the DONE cycle.
   assign accept    = start_i && (state_q != S_RUN);
   // Flipping the sign bit maps two's-complement order onto unsigned order.
   assign sign_flip = {signed_mode_i, {(WIDTH-1){1'b0}}};

   // The captured copies shift left each step, so the current slice is always on top.
   assign a_sl    = a_q[WIDTH-1 -: SLICE];
   assign b_sl    = b_q[WIDTH-1 -: SLICE];
   // Once a verdict exists it is frozen; only an undecided compare looks at the slice.
   assign gt_step = gt_q | (~lt_q & (a_sl > b_sl));
   assign lt_step = lt_q | (~gt_q & (a_sl < b_sl));

`ifdef COMPARE_EARLY_EXIT_EN
   assign finish = (step_q == LAST_STEP) | gt_step | lt_step;
`else
   assign finish = (step_q == LAST_STEP);
`endif

   // Next-state, datapath update and result loading for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      a_d     = a_q;
      b_d     = b_q;
      gt_d    = gt_q;
      lt_d    = lt_q;
      re_d    = re_q;
      reb_d   = reb_q;
      eq_d    = eq_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               state_d = S_RUN;
               step_d  = '0;
               a_d     = a_i ^ sign_flip;
               b_d     = b_i ^ sign_flip;
               gt_d    = 1'b0;
               lt_d    = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            gt_d   = gt_step;
            lt_d   = lt_step;
            a_d    = a_q << SLICE;
            b_d    = b_q << SLICE;
            step_d = step_q + 1'b1;
            if (finish) begin
               state_d = S_DONE;
               re_d    = gt_step;
               reb_d   = lt_step;
               eq_d    = ~(gt_step | lt_step);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any compare in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         step_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
         re_q    <= 1'b0;
         reb_q   <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         a_q     <= a_d;
         b_q     <= b_d;
         gt_q    <= gt_d;
         lt_q    <= lt_d;
         re_q    <= re_d;
         reb_q   <= reb_d;
         eq_q    <= eq_d;
      end
   end

   assign busy_o = (state_q == S_RUN);
   assign done_o = (state_q == S_DONE);
   assign re_o   = re_q;
   assign reb_o  = reb_q;
   assign eq_o   = eq_q;

endmodule

// File: tb/tb_compare_seq.sv
// tb/tb_compare_seq.sv - scoreboard bench for compare_seq at 8/2 and 16/4
module tb_compare_seq;

   typedef struct {
      logic [2:0] v;
      int         t;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start8 = 1'b0, sm8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8, re8, reb8, eq8;
   logic        start16 = 1'b0, sm16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy16, done16, re16, reb16, eq16;

   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   exp_t q8[$];
   exp_t q16[$];

   compare_seq #(.WIDTH(8), .SLICE(2)) dut8 (
      .clk_i(clk), .rst_i(rst), .start_i(start8), .signed_mode_i(sm8),
      .a_i(a8), .b_i(b8), .busy_o(busy8), .done_o(done8),
      .re_o(re8), .reb_o(reb8), .eq_o(eq8)
   );

   compare_seq #(.WIDTH(16), .SLICE(4)) dut16 (
      .clk_i(clk), .rst_i(rst), .start_i(start16), .signed_mode_i(sm16),
      .a_i(a16), .b_i(b16), .busy_o(busy16), .done_o(done16),
      .re_o(re16), .reb_o(reb16), .eq_o(eq16)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [15:0] a_in, input logic [15:0] b_in,
                                  input logic sm, input int w, input int s, input int tacc);
      exp_t        e;
      logic [15:0] a, b, x, mask;
      int          ai, bi, lat, nstep;
      logic        found;
      mask = 16'((32'h1 << w) - 1);
      a = a_in & mask;
      b = b_in & mask;
      ai = int'(a);
      bi = int'(b);
      if (sm && a[w-1]) ai = ai - (1 << w);
      if (sm && b[w-1]) bi = bi - (1 << w);
      e.v = (ai > bi) ? 3'b100 : ((ai < bi) ? 3'b010 : 3'b001);
      nstep = w / s;
      lat = nstep;
      x = a ^ b;
      found = 1'b0;
`ifdef COMPARE_EARLY_EXIT_EN
      for (int k = 0; k < nstep; k++) begin
         if (!found && ((int'(x >> (w - (k + 1) * s)) & ((1 << s) - 1)) != 0)) begin
            lat = k + 1;
            found = 1'b1;
         end
      end
`endif
      e.t = tacc + lat;
      return e;
   endfunction

   // Scoreboard: each done pops one expectation and checks result, cycle and busy.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && done8) begin
         tests++;
         if (q8.size() == 0) begin
            fails++;
            $display("FAIL done8_spurious: done=1 at cycle %0d, required no done", cyc);
         end else begin
            e = q8.pop_front();
            if ({re8, reb8, eq8} !== e.v || cyc != e.t || busy8 !== 1'b0) begin
               fails++;
               $display("FAIL result8: re/reb/eq=%b cycle=%0d busy=%b, required %b cycle=%0d busy=0",
                        {re8, reb8, eq8}, cyc, busy8, e.v, e.t);
            end
         end
      end
      if (!rst && done16) begin
         tests++;
         if (q16.size() == 0) begin
            fails++;
            $display("FAIL done16_spurious: done=1 at cycle %0d, required no done", cyc);
         end else begin
            e = q16.pop_front();
            if ({re16, reb16, eq16} !== e.v || cyc != e.t || busy16 !== 1'b0) begin
               fails++;
               $display("FAIL result16: re/reb/eq=%b cycle=%0d busy=%b, required %b cycle=%0d busy=0",
                        {re16, reb16, eq16}, cyc, busy16, e.v, e.t);
            end
         end
      end
   end

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm);
      int n;
      n = 0;
      @(negedge clk);
      while (busy8 && n < 100) begin
         @(negedge clk);
         n++;
      end
      a8 = a;
      b8 = b;
      sm8 = sm;
      start8 = 1'b1;
      q8.push_back(model({8'h00, a}, {8'h00, b}, sm, 8, 2, cyc + 1));
      @(negedge clk);
      start8 = 1'b0;
   endtask

   task automatic wait_drain(input int which);
      int n;
      n = 0;
      while (((which == 0) ? q8.size() : q16.size()) != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (((which == 0) ? q8.size() : q16.size()) != 0) begin
         fails++;
         $display("FAIL drain_timeout%0d: %0d results pending, required 0", which,
                  (which == 0) ? q8.size() : q16.size());
         if (which == 0) q8.delete();
         else q16.delete();
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if ({busy8, done8, re8, reb8, eq8} !== 5'b0) begin
         fails++;
         $display("FAIL reset8: busy/done/re/reb/eq=%b, required 00000", {busy8, done8, re8, reb8, eq8});
      end
      tests++;
      if ({busy16, done16, re16, reb16, eq16} !== 5'b0) begin
         fails++;
         $display("FAIL reset16: busy/done/re/reb/eq=%b, required 00000", {busy16, done16, re16, reb16, eq16});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      run8(8'hA5, 8'h5A, 1'b0); wait_drain(0);
      run8(8'h80, 8'h01, 1'b1); wait_drain(0);
      run8(8'h80, 8'h01, 1'b0); wait_drain(0);
      run8(8'h3C, 8'h3C, 1'b0); wait_drain(0);
      run8(8'h3C, 8'h3C, 1'b1); wait_drain(0);
      run8(8'hC0, 8'h00, 1'b0); wait_drain(0);
      run8(8'h7F, 8'hFF, 1'b1); wait_drain(0);
      // previous verdict was re=1; it must hold while the next compare runs
      run8(8'h01, 8'h02, 1'b0);
      tests++;
      if ({busy8, re8, reb8, eq8} !== 4'b1100) begin
         fails++;
         $display("FAIL hold_while_busy: busy/re/reb/eq=%b, required 1100", {busy8, re8, reb8, eq8});
      end
      wait_drain(0);
   endtask

   task automatic test_busy_ignore;
      run8(8'h10, 8'h20, 1'b0);
      tests++;
      if (busy8 !== 1'b1) begin
         fails++;
         $display("FAIL ignore_busy: busy=%b, required 1", busy8);
      end
      a8 = 8'hFF;
      b8 = 8'h00;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      wait_drain(0);
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      run8(8'h55, 8'h55, 1'b0);
      repeat (2) @(negedge clk);
      tests++;
      if (busy8 !== 1'b1) begin
         fails++;
         $display("FAIL midrun_busy: busy=%b, required 1", busy8);
      end
      rst = 1'b1;
      #1;
      tests++;
      if ({busy8, done8, re8, reb8, eq8} !== 5'b0) begin
         fails++;
         $display("FAIL midrun_reset: busy/done/re/reb/eq=%b, required 00000", {busy8, done8, re8, reb8, eq8});
      end
      q8.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      tests++;
      if ({busy8, done8, re8, reb8, eq8} !== 5'b0) begin
         fails++;
         $display("FAIL after_abort: busy/done/re/reb/eq=%b, required 00000", {busy8, done8, re8, reb8, eq8});
      end
   endtask

   task automatic test_back_to_back(input int which, input int n);
      int issued, guard;
      issued = 0;
      guard = 0;
      while (issued < n && guard < 20 * n) begin
         @(negedge clk);
         guard++;
         if (which == 0) begin
            a8 = 8'($urandom);
            b8 = ($urandom_range(0, 7) == 0) ? a8 : 8'($urandom);
            sm8 = 1'($urandom);
            if (!busy8) begin
               start8 = 1'b1;
               q8.push_back(model({8'h00, a8}, {8'h00, b8}, sm8, 8, 2, cyc + 1));
               issued++;
            end else begin
               start8 = ($urandom_range(0, 3) == 0);
            end
         end else begin
            a16 = 16'($urandom);
            b16 = ($urandom_range(0, 7) == 0) ? a16 : 16'($urandom);
            sm16 = 1'($urandom);
            if (!busy16) begin
               start16 = 1'b1;
               q16.push_back(model(a16, b16, sm16, 16, 4, cyc + 1));
               issued++;
            end else begin
               start16 = ($urandom_range(0, 3) == 0);
            end
         end
      end
      @(negedge clk);
      start8 = 1'b0;
      start16 = 1'b0;
      wait_drain(which);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back(0, 1000);
      test_back_to_back(1, 1000);
      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
